// File: rtl/sel_enc_regfile_pkg.sv
// Shared constants and types for the bus-receiving register file:
// IR field positions, widths and the register-index type.
package sel_enc_regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned C_W    = 19;

    typedef logic [3:0] reg_idx_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2,
        SEL_C    = 2'd3
    } fld_sel_e;

endpackage

// File: rtl/sel_enc_regfile_decode4to16.sv
// 4-bit register index to 16-bit one-hot decoder; output is all-zero when disabled.
module sel_enc_decode4to16
    import sel_enc_regfile_pkg::*;
(
    input  logic       en_i,
    input  reg_idx_t   idx_i,
    output logic [15:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/sel_enc_regfile.sv
// Register file on the receiving side of the datapath bus: field-select decode,
// 16 loadable registers, write-event counter and sticky error flags.
// Optional build macro SEL_ENC_BAOUT_ZERO_EN presents R0 as zero under ba_out.
module sel_enc_regfile #(
    parameter int unsigned DATA_W = sel_enc_regfile_pkg::DATA_W,
    parameter int unsigned NREGS  = sel_enc_regfile_pkg::NREGS,
    parameter int unsigned CNT_W  = sel_enc_regfile_pkg::CNT_W
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic [DATA_W-1:0]       bus_in,
    input  logic [31:0]             ir,
    input  logic                    gra,
    input  logic                    grb,
    input  logic                    grc,
    input  logic                    r_in,
    input  logic                    r_out,
    input  logic                    ba_out,
    input  logic [NREGS-1:0]        ext_r_in,
    output logic [NREGS*DATA_W-1:0] regs_flat,
    output logic [NREGS-1:0]        rout_onehot,
    output logic [NREGS-1:0]        rin_onehot,
    output logic [DATA_W-1:0]       c_sext,
    output logic [CNT_W-1:0]        write_count,
    output logic [1:0]              err
);

    import sel_enc_regfile_pkg::*;

    fld_sel_e          sel;
    reg_idx_t          fld;
    logic [NREGS-1:0]  dec;
    logic              multi_sel;
    logic              load_overlap;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  write_count_q, write_count_d;
    logic [1:0]        err_q, err_d;

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[31:27];

    always_comb begin
        if (gra) begin
            sel = SEL_A;
        end else if (grb) begin
            sel = SEL_B;
        end else if (grc) begin
            sel = SEL_C;
        end else begin
            sel = SEL_NONE;
        end
    end

    always_comb begin
        fld = '0;
        case (sel)
            SEL_A:   fld = ir[RA_MSB -: 4];
            SEL_B:   fld = ir[RB_MSB -: 4];
            SEL_C:   fld = ir[RC_MSB -: 4];
            default: fld = '0;
        endcase
    end

    sel_enc_decode4to16 u_dec (
        .en_i     (sel != SEL_NONE),
        .idx_i    (fld),
        .onehot_o (dec)
    );

    assign rin_onehot  = (r_in ? dec : '0) | ext_r_in;
    assign rout_onehot = (r_out | ba_out) ? dec : '0;
    assign c_sext      = {{(DATA_W - C_W){ir[C_W-1]}}, ir[C_W-1:0]};

    assign multi_sel    = (gra & grb) | (gra & grc) | (grb & grc);
    assign load_overlap = r_in & (|dec) & (|(ext_r_in & ~dec));

    always_comb begin
        for (int unsigned k = 0; k < NREGS; k++) begin
            regs_d[k] = rin_onehot[k] ? bus_in : regs_q[k];
        end
        write_count_d = (|rin_onehot) ? write_count_q + CNT_W'(1) : write_count_q;
        err_d         = err_q | {load_overlap, multi_sel};
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
            write_count_q <= '0;
            err_q         <= '0;
        end else begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            write_count_q <= write_count_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NREGS; k++) begin
            regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
        end
`ifdef SEL_ENC_BAOUT_ZERO_EN
        // Only the presented view of R0 is masked; the stored value is untouched.
        if (ba_out && dec[0]) begin
            regs_flat[DATA_W-1:0] = '0;
        end
`endif
    end

    assign write_count = write_count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sel_enc_regfile.sv
// Directed bench for sel_enc_regfile with a reference model feeding a scoreboard queue.
module tb_sel_enc_regfile;

    logic          clock = 1'b0;
    logic          clear_n;
    logic [31:0]   bus_in;
    logic [31:0]   ir;
    logic          gra, grb, grc, r_in, r_out, ba_out;
    logic [15:0]   ext_r_in;
    logic [511:0]  regs_flat;
    logic [15:0]   rout_onehot, rin_onehot;
    logic [31:0]   c_sext;
    logic [7:0]    write_count;
    logic [1:0]    err;

    sel_enc_regfile dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .bus_in      (bus_in),
        .ir          (ir),
        .gra         (gra),
        .grb         (grb),
        .grc         (grc),
        .r_in        (r_in),
        .r_out       (r_out),
        .ba_out      (ba_out),
        .ext_r_in    (ext_r_in),
        .regs_flat   (regs_flat),
        .rout_onehot (rout_onehot),
        .rin_onehot  (rin_onehot),
        .c_sext      (c_sext),
        .write_count (write_count),
        .err         (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;

    logic [31:0] mregs [16];
    logic [7:0]  mcnt;
    logic [1:0]  merr;

    function automatic logic [15:0] mdec();
        logic [3:0] f;
        if (gra)      f = ir[26:23];
        else if (grb) f = ir[22:19];
        else if (grc) f = ir[18:15];
        else          return 16'h0000;
        return 16'h0001 << f;
    endfunction

    function automatic logic [31:0] mpres(int k, logic [15:0] d);
`ifdef SEL_ENC_BAOUT_ZERO_EN
        if (k == 0 && ba_out && d[0]) return 32'h0;
`endif
        return mregs[k];
    endfunction

    function automatic logic [31:0] observe(int kind, int idx);
        case (kind)
            0:       return regs_flat[idx*32 +: 32];
            1:       return {24'h0, write_count};
            2:       return {30'h0, err};
            3:       return {16'h0, rin_onehot};
            4:       return {16'h0, rout_onehot};
            default: return c_sext;
        endcase
    endfunction

    task automatic push(string tag, int kind, int idx, logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic check_q();
        exp_t        e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.kind, e.idx);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s[%0d] observed=%h expected=%h", e.tag, e.idx, obs, e.exp);
            end
        end
    endtask

    task automatic push_state();
        logic [15:0] d;
        d = mdec();
        for (int k = 0; k < 16; k++) push("reg", 0, k, mpres(k, d));
        push("write_count", 1, 0, {24'h0, mcnt});
        push("err", 2, 0, {30'h0, merr});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) mregs[k] = 32'h0;
        mcnt = 8'h0;
        merr = 2'b00;
    endtask

    // Called at posedge+1 with inputs already driven; checks decode, then the post-edge state.
    task automatic cycle();
        logic [15:0] d, rin;
        #1;
        d   = mdec();
        rin = (r_in ? d : 16'h0) | ext_r_in;
        push("rin_onehot", 3, 0, {16'h0, rin});
        push("rout_onehot", 4, 0, {16'h0, ((r_out | ba_out) ? d : 16'h0)});
        push("c_sext", 5, 0, {{13{ir[18]}}, ir[18:0]});
        check_q();
        if (int'(gra) + int'(grb) + int'(grc) >= 2) merr[0] = 1'b1;
        if (r_in && d != 16'h0 && (ext_r_in & ~d) != 16'h0) merr[1] = 1'b1;
        if (rin != 16'h0) mcnt = mcnt + 8'd1;
        for (int k = 0; k < 16; k++) if (rin[k]) mregs[k] = bus_in;
        @(posedge clock);
        #1;
        push_state();
        check_q();
    endtask

    task automatic idle_inputs();
        gra = 0; grb = 0; grc = 0; r_in = 0; r_out = 0; ba_out = 0;
        ext_r_in = 16'h0; ir = 32'h0; bus_in = 32'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        clear_n = 1'b0;
        model_reset();
        #2;
        push_state();
        check_q();
        @(posedge clock);
        #1;
        clear_n = 1'b1;

        // Ra=5 load
        ir = 32'h0280_0000; gra = 1; r_in = 1; bus_in = 32'hDEAD_BEEF;
        cycle();
        push("tp_r5", 0, 5, 32'hDEAD_BEEF);
        push("tp_cnt", 1, 0, 32'd1);
        check_q();

        // Rb=3 drive only
        idle_inputs();
        ir = 32'h0298_0000; grb = 1; r_out = 1; bus_in = 32'h1111_1111;
        cycle();

        // gra and grc together: priority to Ra, err[0] sticky
        idle_inputs();
        ir = 32'h0104_8000; gra = 1; grc = 1; r_in = 1; bus_in = 32'hA5A5_0002;
        cycle();
        push("tp_err0", 2, 0, 32'd1);
        check_q();
        idle_inputs();
        cycle();

        // decoded and direct loads overlap
        ir = 32'h0200_0000; gra = 1; r_in = 1; ext_r_in = 16'h0100; bus_in = 32'h1234_5678;
        cycle();
        push("tp_r8", 0, 8, 32'h1234_5678);
        check_q();

        // sign extension, both polarities; r_in with no select loads nothing
        idle_inputs();
        ir = 32'h0004_0001; r_in = 1;
        cycle();
        ir = 32'h0000_0010;
        cycle();

        // load while reset held is suppressed, including the edge itself
        idle_inputs();
        ir = 32'h0180_0000; gra = 1; r_in = 1; bus_in = 32'h5555_AAAA;
        #3;
        clear_n = 1'b0;
        #1;
        model_reset();
        push_state();
        check_q();
        @(posedge clock);
        #1;
        push_state();
        check_q();
        clear_n = 1'b1;

        // counter wrap: 256 loads from a reset count
        idle_inputs();
        ext_r_in = 16'h0001;
        for (int i = 0; i < 256; i++) begin
            bus_in = 32'h100 + i;
            cycle();
        end
        push("tp_wrap", 1, 0, 32'd0);
        check_q();

        // mid-cycle reset after the wrap
        idle_inputs();
        #3;
        clear_n = 1'b0;
        #1;
        model_reset();
        push_state();
        check_q();
        @(posedge clock);
        #1;
        clear_n = 1'b1;

        // R0 presentation under ba_out vs r_out
        ext_r_in = 16'h0001; bus_in = 32'h7;
        cycle();
        idle_inputs();
        gra = 1; ba_out = 1;
        cycle();
`ifdef SEL_ENC_BAOUT_ZERO_EN
        push("tp_ba_r0", 0, 0, 32'h0);
`else
        push("tp_ba_r0", 0, 0, 32'h7);
`endif
        check_q();
        ba_out = 0; r_out = 1;
        cycle();
        push("tp_rout_r0", 0, 0, 32'h7);
        check_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sel_enc_regfile.md
Name: sel_enc_regfile

Overview:
- Receiving end of the shared 32-bit datapath bus.
- Decodes instruction-register fields into one-hot register load (Rin) and drive (Rout) strobes.
- Holds the 16 general-purpose registers and loads them from the bus.
- Presents register contents, one-hot drive requests and the sign-extended C constant back toward the bus multiplexer.

Parameters:
- DATA_W, 32, bus and register width.
- NREGS, 16, number of general-purpose registers. Fixed by the 4-bit IR fields.
- CNT_W, 8, width of the write-event counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- bus_in  in  DATA_W  shared bus value to be captured.
- ir  in  32  instruction register. Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15], C=ir[18:0].
- gra, grb, grc  in  1 each  select Ra / Rb / Rc field.
- r_in  in  1  load the selected register from bus_in.
- r_out  in  1  request the selected register to drive the bus.
- ba_out  in  1  base-address drive request (same decode as r_out).
- ext_r_in  in  NREGS  direct one-hot load enables, for datapath bring-up.
- regs_flat  out  NREGS*DATA_W  register contents; Rk at bits [32k+31:32k].
- rout_onehot  out  NREGS  per-register drive requests, bit k = RkOut.
- rin_onehot  out  NREGS  effective load enables this cycle.
- c_sext  out  DATA_W  ir[18:0] sign-extended from bit 18.
- write_count  out  CNT_W  number of clock edges on which at least one register loaded.
- err  out  2  sticky status. Bit0 = multiple field selects; bit1 = load-enable overlap.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - all 16 registers, write_count and err go to 0 immediately.
  - Loads are suppressed while clear_n is low.
  - Reset applied mid-load wins: no register captures bus_in on that edge.
- Field select (combinational):
  - Priority is gra > grb > grc.
  - fld = Ra if gra, else Rb if grb, else Rc if grc.
  - With no select asserted, dec = 0; otherwise dec = one-hot of fld.
- rin_onehot = (r_in ? dec : 0) | ext_r_in.
- rout_onehot = ((r_out | ba_out) ? dec : 0).
- c_sext = {13 copies of ir[18], ir[18:0]}. Purely combinational.
- Register load:
  - On a rising edge with rin_onehot[k]=1, Rk <= bus_in. Latency is 1 cycle; the new value is visible on regs_flat after the edge.
  - Registers with rin_onehot[k]=0 hold.
  - Multiple set bits load all flagged registers with the same bus_in.
- write_count:
  - Increments by 1 on every edge where rin_onehot != 0.
  - Wraps 2^CNT_W-1 -> 0 with no flag.
- err[0]: set on any edge where two or more of gra/grb/grc are high; decode still follows priority.
- err[1]: set on any edge where r_in=1, dec!=0 and (ext_r_in & ~dec) != 0, i.e. decoded and direct loads target different registers.
- err bits are sticky until clear_n.
- r_in and r_out may be asserted together. The selected register drives the old value; the new bus value is captured at the edge. No combinational loop exists inside the block.

Optional Feature:
- Macro: SEL_ENC_BAOUT_ZERO_EN.
- Defined:
  - When ba_out=1 and dec selects R0, regs_flat[31:0] reads 0 (R0 as constant zero for base addressing).
  - R0 storage is unaffected.
  - r_out alone still presents the true R0.
- Undefined:
  - ba_out behaves identically to r_out.
  - R0 is always presented as stored.

Decomposition:
- Shared package contents:
  - Field bit positions (RA_MSB=26, RB_MSB=22, RC_MSB=18).
  - C_W=19, NREGS, DATA_W.
  - A 4-bit register-index typedef.
- Sub-module: sel_enc_decode4to16, the 4-bit to 16 one-hot decoder with enable.
- The register array, counter and error logic stay in the top module.

Test Plan:
- Reset, then ir with Ra=5 (ir=32'h0280_0000), gra=1, r_in=1, bus_in=32'hDEAD_BEEF, one edge -> R5=DEADBEEF, other registers 0, write_count=1, rin_onehot=16'h0020.
- Same ir with grb=1 and Rb=3 (ir[22:19]=3), r_out=1 -> rout_onehot=16'h0008; no register changes; write_count unchanged.
- gra=1 and grc=1 together, r_in=1, Ra=2, Rc=9 -> only R2 loads; err=2'b01 and stays set after both deassert.
- r_in=1, Ra=4 via gra, ext_r_in=16'h0100, bus_in=32'h1234_5678 -> R4 and R8 both = 12345678; err[1]=1.
- ir[18:0]=19'h40001 -> c_sext=32'hFFFC_0001; ir[18:0]=19'h00010 -> 32'h0000_0010.
- Load 255 then 1 more with ext_r_in=16'h0001 -> write_count wraps to 0. Pulse clear_n low mid-cycle -> all outputs 0 immediately.
- With SEL_ENC_BAOUT_ZERO_EN: R0=7, ba_out=1, Ra=0 -> regs_flat[31:0]=0; with r_out only -> 7.
